bsg_fifo_1r1w_sync_mem_ctrl: RTL and testbench
==============================================

// Module: bsg_fifo_1r1w_sync_mem_ctrl
// PURPOSE
//  Sequencer turning an external bsg_mem_1r1w_sync into a ready/valid FIFO of els_p+1 entries.
//  Drives the RAM write/read ports and tracks pointers and occupancy.
//  Issues prefetch reads so the RAM read latch is the output register: 1 elem/cycle, 2-cycle fill latency.
//  Never issues same-address read+write, so the RAM runs with read_write_same_addr_p=0.
//  Required RAM setting: latch_last_read_p=1.
// PARAMETERS
//  width_p   (none, BSG_INV_PARAM)  element width in bits
//  els_p     (none, BSG_INV_PARAM)  RAM depth, >=2; any value, non-power-of-2 allowed
//  addr_width_lp  BSG_SAFE_CLOG2(els_p)    RAM address width
//  cnt_width_lp   BSG_WIDTH(els_p)         RAM occupancy counter width
// PORTS
//  clk_i          in   1             clock; all state on posedge
//  reset_i        in   1             synchronous, active-high reset
//  v_i            in   1             enqueue valid
//  ready_and_o    in/out: out 1      enqueue ready; transfer = v_i & ready_and_o
//  data_i         in   width_p       enqueue data
//  v_o            out  1             head valid
//  data_o         out  width_p       head data (= mem_r_data_i)
//  yumi_i         in   1             dequeue; legal only when v_o=1
//  mem_w_v_o      out  1             RAM write enable
//  mem_w_addr_o   out  addr_width_lp RAM write address (= wptr)
//  mem_w_data_o   out  width_p       RAM write data (= data_i)
//  mem_r_v_o      out  1             RAM read enable
//  mem_r_addr_o   out  addr_width_lp RAM read address (= rptr)
//  mem_r_data_i   in   width_p       RAM read data, valid cycle after mem_r_v_o
// BEHAVIOUR
//  State: wptr, rptr (0..els_p-1, wrap els_p-1 -> 0); cnt = unread RAM entries (0..els_p); v_o reg.
//  Reset (reset_i=1 at posedge): wptr=rptr=0, cnt=0, v_o=0.
//   ready_and_o=0, mem_w_v_o=0, mem_r_v_o=0 combinationally while reset_i=1.
//  ready_and_o = ~reset_i & (cnt != els_p); independent of yumi_i (no same-cycle pass-through).
//  enq = v_i & ready_and_o; mem_w_v_o = enq; on enq wptr advances.
//  deq_ok = ~v_o | yumi_i   (head empty or vacating this cycle).
//  rd = ~reset_i & (cnt != 0) & deq_ok; mem_r_v_o = rd; on rd rptr advances.
//  cnt_next = cnt + enq - rd; simultaneous enq and rd leaves cnt unchanged.
//  v_o_next = rd | (v_o & ~yumi_i).
//  data_o = mem_r_data_i; RAM latch holds it while v_o=1 and no new read.
//  Latency: enq at cycle t -> rd at t+1 at the earliest -> v_o=1 at t+2.
//  Throughput: with yumi_i held high and cnt>0, one element per cycle.
//  Collision-free: rd needs cnt>0, enq needs cnt<els_p.
//   Hence wptr==rptr never coincides with both ports active.
//  Total capacity els_p+1: els_p in RAM plus one in head latch.
//   The head's RAM slot is freed at read issue.
//  Full: cnt==els_p -> ready_and_o=0 until a rd.
//   A yumi_i in the full state lets a new enq in the next cycle.
//  Empty: cnt==0 & v_o=0 -> no read; yumi_i must be 0.
//  Order is strict FIFO across pointer wrap.
//  Reset mid-operation: all contents discarded; v_o=0 the cycle after reset.
//  Assertion (non-synth): yumi_i & ~v_o is an $error.
// TESTING
//  1 Reset, push A=0x11 at t0 -> mem_w_addr_o=0 @t0, mem_r_v_o @t1, v_o=1 data_o=0x11 @t2.
//  2 els_p=4: push 5 with yumi_i=0 -> ready_and_o=0 after the 5th.
//    Pop 1 -> ready_and_o=1 next cycle; order preserved.
//  3 Stream 20 items with v_i=1, yumi_i=1 (els_p=3, non-pow2) -> 1/cycle after fill.
//    Outputs 0..19 in order; pointers wrap 2->0.
//  4 Head held 5 cycles with yumi_i=0 and cnt>0 -> mem_r_v_o=0 and data_o stable throughout.
//  5 Every cycle: never (mem_w_v_o & mem_r_v_o & addrs equal).
//    Random v_i/yumi_i for 10k cycles vs scoreboard model.
//  6 Assert reset_i with 3 items queued -> v_o=0 and ready_and_o=1 after reset.
//    Next push reappears at 2-cycle latency.

Source files
------------

// File: rtl/bsg_fifo_1r1w_sync_mem_ctrl.sv
// Control logic that turns an external 1r1w synchronous RAM (latch_last_read_p=1,
// read_write_same_addr_p=0) into a ready/valid FIFO of els_p+1 entries.
module bsg_fifo_1r1w_sync_mem_ctrl #(
  parameter  int width_p       = 8,
  parameter  int els_p         = 4,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int cnt_width_lp  = $clog2(els_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     v_i,
  output logic                     ready_and_o,
  input  logic [width_p-1:0]       data_i,

  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,

  output logic                     mem_w_v_o,
  output logic [addr_width_lp-1:0] mem_w_addr_o,
  output logic [width_p-1:0]       mem_w_data_o,
  output logic                     mem_r_v_o,
  output logic [addr_width_lp-1:0] mem_r_addr_o,
  input  logic [width_p-1:0]       mem_r_data_i
);

  localparam logic [cnt_width_lp-1:0]  full_cnt_lp  = cnt_width_lp'(els_p);
  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

  logic [addr_width_lp-1:0] wptr_r;
  logic [addr_width_lp-1:0] rptr_r;
  logic [cnt_width_lp-1:0]  cnt_r;
  logic                     v_r;

  logic enq;
  logic deq_ok;
  logic rd;

  function automatic logic [addr_width_lp-1:0] ptr_inc(input logic [addr_width_lp-1:0] p);
    return (p == last_addr_lp) ? '0 : p + addr_width_lp'(1);
  endfunction

  // cnt_r counts RAM entries not yet read; the head element lives in the RAM read latch.
  assign ready_and_o = ~reset_i & (cnt_r != full_cnt_lp);
  assign enq         = v_i & ready_and_o;
  assign deq_ok      = ~v_r | yumi_i;
  assign rd          = ~reset_i & (cnt_r != '0) & deq_ok;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
      v_r    <= 1'b0;
    end else begin
      if (enq) wptr_r <= ptr_inc(wptr_r);
      if (rd)  rptr_r <= ptr_inc(rptr_r);
      case ({enq, rd})
        2'b10:   cnt_r <= cnt_r + cnt_width_lp'(1);
        2'b01:   cnt_r <= cnt_r - cnt_width_lp'(1);
        default: cnt_r <= cnt_r;
      endcase
      v_r <= rd | (v_r & ~yumi_i);
    end
  end

  assign v_o          = v_r;
  assign data_o       = mem_r_data_i;
  assign mem_w_v_o    = enq;
  assign mem_w_addr_o = wptr_r;
  assign mem_w_data_o = data_i;
  assign mem_r_v_o    = rd;
  assign mem_r_addr_o = rptr_r;

`ifndef SYNTHESIS
  // Dequeueing an empty head would silently corrupt the occupancy count.
  assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_r))
    else $error("bsg_fifo_1r1w_sync_mem_ctrl: yumi_i asserted while v_o=0");
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_sync_mem_ctrl.sv
// Bench for bsg_fifo_1r1w_sync_mem_ctrl: two instances (els_p=4 and els_p=3), each with
// a behavioural sync RAM, checked against a per-instance scoreboard.
module tb_bsg_fifo_1r1w_sync_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // index 0 -> els_p=4, index 1 -> els_p=3
  int els [2] = '{4, 3};

  logic       vi    [2];
  logic       rdy   [2];
  logic [7:0] din   [2];
  logic       vo    [2];
  logic [7:0] dout  [2];
  logic       yumi  [2];
  logic       wv    [2];
  logic [1:0] wa    [2];
  logic [7:0] wd    [2];
  logic       rv    [2];
  logic [1:0] ra    [2];
  logic [7:0] rdata [2];

  logic [7:0] mem4 [4];
  logic [7:0] mem3 [3];

  bsg_fifo_1r1w_sync_mem_ctrl #(.width_p(8), .els_p(4)) u_dut4 (
    .clk_i(clk), .reset_i(rst),
    .v_i(vi[0]), .ready_and_o(rdy[0]), .data_i(din[0]),
    .v_o(vo[0]), .data_o(dout[0]), .yumi_i(yumi[0]),
    .mem_w_v_o(wv[0]), .mem_w_addr_o(wa[0]), .mem_w_data_o(wd[0]),
    .mem_r_v_o(rv[0]), .mem_r_addr_o(ra[0]), .mem_r_data_i(rdata[0])
  );

  bsg_fifo_1r1w_sync_mem_ctrl #(.width_p(8), .els_p(3)) u_dut3 (
    .clk_i(clk), .reset_i(rst),
    .v_i(vi[1]), .ready_and_o(rdy[1]), .data_i(din[1]),
    .v_o(vo[1]), .data_o(dout[1]), .yumi_i(yumi[1]),
    .mem_w_v_o(wv[1]), .mem_w_addr_o(wa[1]), .mem_w_data_o(wd[1]),
    .mem_r_v_o(rv[1]), .mem_r_addr_o(ra[1]), .mem_r_data_i(rdata[1])
  );

  // Sync RAMs with read latch holding the last read value.
  always @(posedge clk) begin
    if (wv[0]) mem4[wa[0]] <= wd[0];
    if (rv[0]) rdata[0]    <= mem4[ra[0]];
    if (wv[1]) mem3[wa[1]] <= wd[1];
    if (rv[1]) rdata[1]    <= mem3[ra[1]];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: contents accepted and not yet dequeued (RAM entries + head).
  logic [7:0] sb [2][$];
  int wp [2];
  int rp [2];

  always @(negedge clk) begin
    int in_ram;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        chk("rst_ready", 32'(rdy[k]), 32'(0));
        chk("rst_w_v",   32'(wv[k]),  32'(0));
        chk("rst_r_v",   32'(rv[k]),  32'(0));
        sb[k].delete();
        wp[k] = 0;
        rp[k] = 0;
      end else begin
        in_ram = sb[k].size() - int'(vo[k]);
        chk("ready",   32'(rdy[k]), 32'(in_ram != els[k]));
        chk("w_v",     32'(wv[k]),  32'(vi[k] && (in_ram != els[k])));
        chk("r_v",     32'(rv[k]),  32'((in_ram != 0) && (!vo[k] || yumi[k])));
        chk("collide", 32'(wv[k] && rv[k] && (wa[k] == ra[k])), 32'(0));
        if (wv[k]) begin
          chk("w_addr", 32'(wa[k]), 32'(wp[k]));
          chk("w_data", 32'(wd[k]), 32'(din[k]));
          wp[k] = (wp[k] + 1) % els[k];
        end
        if (rv[k]) begin
          chk("r_addr", 32'(ra[k]), 32'(rp[k]));
          rp[k] = (rp[k] + 1) % els[k];
        end
        if (vo[k] && yumi[k]) begin
          if (sb[k].size() == 0) chk("underflow", 32'(1), 32'(0));
          else                   chk("data", 32'(dout[k]), 32'(sb[k].pop_front()));
        end
        if (vi[k] && rdy[k]) sb[k].push_back(din[k]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 40; i++) begin
      cyc();
      vi[k]   = 1'b0;
      yumi[k] = vo[k];
      if (!vo[k] && sb[k].size() == 0) break;
    end
    yumi[k] = 1'b0;
    #1;
    chk("drain_empty", 32'(sb[k].size()), 32'(0));
    chk("drain_vo",    32'(vo[k]),        32'(0));
  endtask

  int sent, got, fp, fo, lo;

  initial begin
    for (int k = 0; k < 2; k++) begin
      vi[k] = 1'b0; din[k] = '0; yumi[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    chk("reset_vo",    32'(vo[0]),  32'(0));
    chk("reset_ready", 32'(rdy[0]), 32'(1));

    // 2-cycle fill latency
    cyc(); vi[0] = 1'b1; din[0] = 8'h11; #1;
    chk("t1_wv", 32'(wv[0]), 32'(1));
    chk("t1_waddr", 32'(wa[0]), 32'(0));
    cyc(); vi[0] = 1'b0; #1;
    chk("t1_rv", 32'(rv[0]), 32'(1));
    chk("t1_vo_early", 32'(vo[0]), 32'(0));
    cyc(); #1;
    chk("t1_vo", 32'(vo[0]), 32'(1));
    chk("t1_data", 32'(dout[0]), 32'h11);
    drain(0);

    // Full at els_p+1 = 5 entries
    for (int i = 0; i < 5; i++) begin
      cyc(); vi[0] = 1'b1; din[0] = 8'(8'h20 + i); #1;
      chk("t2_ready_pre", 32'(rdy[0]), 32'(1));
    end
    cyc(); vi[0] = 1'b0; #1;
    chk("t2_full", 32'(rdy[0]), 32'(0));
    cyc(); #1;
    chk("t2_full_hold", 32'(rdy[0]), 32'(0));
    chk("t2_vo", 32'(vo[0]), 32'(1));
    yumi[0] = 1'b1; #1;
    chk("t2_ready_same_cycle", 32'(rdy[0]), 32'(0));
    cyc(); yumi[0] = 1'b0; #1;
    chk("t2_ready_after_pop", 32'(rdy[0]), 32'(1));
    vi[0] = 1'b1; din[0] = 8'h25;
    cyc(); vi[0] = 1'b0;
    drain(0);

    // Streaming through els_p=3 with pointer wrap
    sent = 0; got = 0; fp = 0; fo = 0; lo = 0;
    for (int c = 0; c < 80 && got < 20; c++) begin
      cyc();
      vi[1]   = (sent < 20);
      din[1]  = 8'(sent);
      yumi[1] = vo[1];
      #1;
      if (vi[1] && rdy[1]) begin
        if (sent == 0) fp = c;
        sent++;
      end
      if (vo[1] && yumi[1]) begin
        chk("t3_order", 32'(dout[1]), 32'(got));
        if (got == 0) fo = c;
        lo = c;
        got++;
      end
    end
    cyc(); vi[1] = 1'b0; yumi[1] = 1'b0;
    chk("t3_count", 32'(got), 32'(20));
    chk("t3_latency", 32'(fo - fp), 32'(2));
    chk("t3_rate", 32'(lo - fo), 32'(19));
    drain(1);

    // Head held with backlog in RAM
    for (int i = 0; i < 3; i++) begin
      cyc(); vi[0] = 1'b1; din[0] = 8'(8'h40 + i);
    end
    cyc(); vi[0] = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_vo", 32'(vo[0]), 32'(1));
      chk("t4_rv", 32'(rv[0]), 32'(0));
      chk("t4_hold", 32'(dout[0]), 32'h40);
      cyc(); #1;
    end
    drain(0);

    // Reset with items queued
    for (int i = 0; i < 3; i++) begin
      cyc(); vi[0] = 1'b1; din[0] = 8'(8'h60 + i);
    end
    cyc(); vi[0] = 1'b0; rst = 1'b1; #1;
    chk("t6_vo_pre", 32'(vo[0]), 32'(1));
    cyc(); rst = 1'b0; #1;
    chk("t6_vo", 32'(vo[0]), 32'(0));
    chk("t6_ready", 32'(rdy[0]), 32'(1));
    vi[0] = 1'b1; din[0] = 8'h5A;
    cyc(); vi[0] = 1'b0; #1;
    chk("t6_vo_t1", 32'(vo[0]), 32'(0));
    cyc(); #1;
    chk("t6_vo_t2", 32'(vo[0]), 32'(1));
    chk("t6_data", 32'(dout[0]), 32'h5A);
    drain(0);

    // Random traffic on both instances; first half fills, second half drains
    for (int c = 0; c < 10000; c++) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        vi[k]   = 1'($urandom_range(0, 1));
        din[k]  = 8'($urandom);
        yumi[k] = vo[k] & ((c < 5000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      end
    end
    cyc();
    for (int k = 0; k < 2; k++) begin
      vi[k] = 1'b0; yumi[k] = 1'b0;
    end
    drain(0);
    drain(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
